// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register readback transmitter: FSM states,
// snapshot field layout, frame geometry and the byte/checksum helpers.
package reg_dump_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } state_e;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    // Field positions inside the 32-bit snapshot word
    localparam int F_A_LSB = 0;
    localparam int F_A_W   = 8;
    localparam int F_B_LSB = 8;
    localparam int F_B_W   = 13;
    localparam int F_C_LSB = 21;
    localparam int F_C_W   = 5;
    localparam int F_D_LSB = 26;
    localparam int F_D_W   = 3;
    localparam int F_E_LSB = 29;
    localparam int F_E_W   = 1;

    localparam int WORD_W      = 32;
    localparam int FRAME_BYTES = 6;

    // Index of the last data byte: the frame is header + data + checksum
    localparam logic [1:0] LAST_IDX = 2'(FRAME_BYTES - 3);

    // Assemble the snapshot word; the two top bits stay zero
    function automatic logic [WORD_W-1:0] pack_word(
        input logic [F_A_W-1:0] a,
        input logic [F_B_W-1:0] b,
        input logic [F_C_W-1:0] c,
        input logic [F_D_W-1:0] d,
        input logic [F_E_W-1:0] e
    );
        logic [WORD_W-1:0] w;
        w = 32'h0000_0000;
        w[F_A_LSB +: F_A_W] = a;
        w[F_B_LSB +: F_B_W] = b;
        w[F_C_LSB +: F_C_W] = c;
        w[F_D_LSB +: F_D_W] = d;
        w[F_E_LSB +: F_E_W] = e;
        return w;
    endfunction

    // Select one little-endian byte of the snapshot word
    function automatic logic [7:0] word_byte(
        input logic [WORD_W-1:0] w,
        input logic [1:0]        idx
    );
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Frame checksum: XOR of the four data bytes, header excluded
    function automatic logic [7:0] xor_csum(input logic [WORD_W-1:0] w);
        return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    endfunction

endpackage

// File: rtl/reg_dump_tx.sv
// Register readback transmitter. A request snapshots the register fields
// into one word and streams it as HEADER, 4 data bytes, XOR checksum over
// a valid/ready byte interface. All outputs come straight from flops.
module reg_dump_tx
    import reg_dump_pkg::*;
#(
    parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [7:0]  r8,
    input  logic [12:0] r13,
    input  logic [4:0]  r5,
    input  logic [2:0]  r3,
    input  logic        r1,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    state_e              state_r;
    state_e              state_s;
    logic [1:0]          idx_r;
    logic [1:0]          idx_s;
    logic [WORD_W-1:0]   snap_r;
    logic [7:0]          csum_r;
    logic [WORD_W-1:0]   word_s;
    logic                capture_s;
    logic                xfer_s;
    logic [7:0]          tx_data_s;
    logic                tx_valid_s;
    logic                busy_s;
    logic                done_s;

    assign word_s = pack_word(r8, r13, r5, r3, r1);
    assign xfer_s = tx_valid & tx_ready;

    // Next-state and next-output decode; the byte for the next beat is
    // prepared here so tx_data can be a plain register
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        tx_data_s  = tx_data;
        tx_valid_s = tx_valid;
        busy_s     = busy;
        done_s     = 1'b0;
        capture_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (req) begin
                    capture_s  = 1'b1;
                    state_s    = HDR;
                    idx_s      = 2'd0;
                    tx_data_s  = HEADER;
                    tx_valid_s = 1'b1;
                    busy_s     = 1'b1;
                end else begin
                    tx_data_s  = 8'h00;
                    tx_valid_s = 1'b0;
                    busy_s     = 1'b0;
                end
            end
            HDR: begin
                if (xfer_s) begin
                    state_s   = DATA;
                    idx_s     = 2'd0;
                    tx_data_s = word_byte(snap_r, 2'd0);
                end else begin
                    state_s   = HDR;
                end
            end
            DATA: begin
                if (xfer_s) begin
                    if (idx_r == LAST_IDX) begin
                        state_s   = CSUM;
                        idx_s     = 2'd0;
                        tx_data_s = csum_r;
                    end else begin
                        idx_s     = idx_r + 2'd1;
                        tx_data_s = word_byte(snap_r, idx_r + 2'd1);
                    end
                end else begin
                    state_s = DATA;
                end
            end
            CSUM: begin
                if (xfer_s) begin
                    state_s    = IDLE;
                    tx_data_s  = 8'h00;
                    tx_valid_s = 1'b0;
                    busy_s     = 1'b0;
                    done_s     = 1'b1;
                end else begin
                    state_s = CSUM;
                end
            end
            default: begin
                state_s    = IDLE;
                idx_s      = 2'd0;
                tx_data_s  = 8'h00;
                tx_valid_s = 1'b0;
                busy_s     = 1'b0;
            end
        endcase
    end

    // FSM state, byte index and registered interface outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            idx_r    <= 2'd0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_r  <= state_s;
            idx_r    <= idx_s;
            tx_data  <= tx_data_s;
            tx_valid <= tx_valid_s;
            busy     <= busy_s;
            done     <= done_s;
        end
    end

    // Snapshot and checksum capture; both freeze for the whole frame
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_r <= 32'h0000_0000;
            csum_r <= 8'h00;
        end else if (capture_s) begin
            snap_r <= word_s;
            csum_r <= xor_csum(word_s);
        end else begin
            snap_r <= snap_r;
            csum_r <= csum_r;
        end
    end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Directed bench for reg_dump_tx: inputs change and outputs are sampled on
// the falling clock edge, away from the active rising edge.
module tb_reg_dump_tx;

    logic        clk;
    logic        rst;
    logic        req;
    logic [7:0]  r8;
    logic [12:0] r13;
    logic [4:0]  r5;
    logic [2:0]  r3;
    logic        r1;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    int tests_run;
    int tests_failed;

    localparam logic [47:0] FRAME_A = 48'hA5_3C_BC_BA_36_0C;
    localparam logic [47:0] FRAME_Z = 48'hA5_00_00_00_00_00;

    reg_dump_tx dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .r8       (r8),
        .r13      (r13),
        .r5       (r5),
        .r3       (r3),
        .r1       (r1),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_regs_a();
        r8 = 8'h3C; r13 = 13'h1ABC; r5 = 5'h15; r3 = 3'd5; r1 = 1'b1;
    endtask

    // Pulse req for one cycle; on return the header beat is visible
    task automatic pulse_req();
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    // Receive up to maxn beats, stalling 'stall' cycles before each beat.
    // Records the bytes and counts cycles where valid dropped or the
    // presented byte moved while stalled. Bounded by a cycle budget.
    task automatic collect(input int stall, input int maxn,
                           output logic [47:0] got, output int n,
                           output int cycles, output int unstable);
        int sc;
        logic [7:0] held;
        got = 48'h0; n = 0; cycles = 0; unstable = 0; sc = 0; held = 8'h00;
        while (n < maxn && cycles < 300) begin
            if (sc < stall) begin
                tx_ready = 1'b0;
                sc++;
            end else begin
                tx_ready = 1'b1;
            end
            if (!tx_valid) begin
                unstable++;
            end else if (tx_ready) begin
                got = {got[39:0], tx_data};
                n++;
                if (stall > 0 && tx_data !== held) unstable++;
                sc = 0;
            end else if (sc == 1) begin
                held = tx_data;
            end else if (tx_data !== held) begin
                unstable++;
            end
            cycles++;
            @(negedge clk);
        end
        tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; tx_ready = 1'b1;
        r8 = 8'h00; r13 = 13'h0; r5 = 5'h0; r3 = 3'd0; r1 = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
        tests_run++; if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h want 00", tx_data); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_normal();
        logic [47:0] got; int n, cyc, bad;
        set_regs_a();
        pulse_req();
        tests_run++; if (tx_valid !== 1'b1) begin tests_failed++; $display("FAIL normal_hdr_valid: got %b want 1", tx_valid); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL normal_hdr_busy: got %b want 1", busy); end
        tests_run++; if (tx_data !== 8'hA5) begin tests_failed++; $display("FAIL normal_hdr_data: got %h want a5", tx_data); end
        collect(0, 6, got, n, cyc, bad);
        tests_run++; if (n !== 6) begin tests_failed++; $display("FAIL normal_count: got %0d want 6", n); end
        tests_run++; if (got !== FRAME_A) begin tests_failed++; $display("FAIL normal_bytes: got %h want %h", got, FRAME_A); end
        tests_run++; if (cyc !== 6) begin tests_failed++; $display("FAIL normal_cycles: got %0d want 6", cyc); end
        tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL normal_gap: got %0d want 0", bad); end
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL normal_done: got %b want 1", done); end
        tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL normal_end_valid: got %b want 0", tx_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL normal_end_busy: got %b want 0", busy); end
        @(negedge clk);
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL normal_done_width: got %b want 0", done); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL normal_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        logic [47:0] got; int n, cyc, bad;
        set_regs_a();
        tx_ready = 1'b0;
        pulse_req();
        collect(3, 6, got, n, cyc, bad);
        tests_run++; if (n !== 6) begin tests_failed++; $display("FAIL bp_count: got %0d want 6", n); end
        tests_run++; if (got !== FRAME_A) begin tests_failed++; $display("FAIL bp_bytes: got %h want %h", got, FRAME_A); end
        tests_run++; if (cyc !== 24) begin tests_failed++; $display("FAIL bp_cycles: got %0d want 24", cyc); end
        tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL bp_stable: got %0d want 0", bad); end
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL bp_done: got %b want 1", done); end
        @(negedge clk);
        tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_extra: got %b want 0", tx_valid); end
    endtask

    task automatic test_input_change();
        logic [47:0] got; int n, cyc, bad;
        set_regs_a();
        pulse_req();
        r8 = 8'hFF; r1 = 1'b0;
        collect(0, 6, got, n, cyc, bad);
        tests_run++; if (got !== FRAME_A) begin tests_failed++; $display("FAIL inchg_bytes: got %h want %h", got, FRAME_A); end
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL inchg_done: got %b want 1", done); end
        set_regs_a();
        @(negedge clk);
    endtask

    task automatic test_held_req();
        logic [47:0] got; int n, cyc, bad;
        set_regs_a();
        req = 1'b1;
        @(negedge clk);
        collect(0, 6, got, n, cyc, bad);
        tests_run++; if (got !== FRAME_A) begin tests_failed++; $display("FAIL held_bytes: got %h want %h", got, FRAME_A); end
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL held_done: got %b want 1", done); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL held_gap_busy: got %b want 0", busy); end
        // req is still high in the done cycle, so a new frame must start
        @(negedge clk);
        req = 1'b0;
        tests_run++; if (tx_data !== 8'hA5) begin tests_failed++; $display("FAIL b2b_hdr: got %h want a5", tx_data); end
        tests_run++; if (tx_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_valid: got %b want 1", tx_valid); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_busy: got %b want 1", busy); end
        collect(0, 6, got, n, cyc, bad);
        tests_run++; if (got !== FRAME_A) begin tests_failed++; $display("FAIL b2b_bytes: got %h want %h", got, FRAME_A); end
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL b2b_done: got %b want 1", done); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [47:0] got; int n, cyc, bad;
        set_regs_a();
        pulse_req();
        collect(0, 3, got, n, cyc, bad);
        tests_run++; if (got[23:0] !== 24'hA5_3C_BC) begin tests_failed++; $display("FAIL mid_prefix: got %h want a53cbc", got[23:0]); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_valid: got %b want 0", tx_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy: got %b want 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL mid_done: got %b want 0", done); end
        @(negedge clk);
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL mid_no_done: got %b want 0", done); end
        pulse_req();
        collect(0, 6, got, n, cyc, bad);
        tests_run++; if (got !== FRAME_A) begin tests_failed++; $display("FAIL mid_refr_bytes: got %h want %h", got, FRAME_A); end
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL mid_refr_done: got %b want 1", done); end
        @(negedge clk);
    endtask

    task automatic test_zeros();
        logic [47:0] got; int n, cyc, bad;
        r8 = 8'h00; r13 = 13'h0; r5 = 5'h0; r3 = 3'd0; r1 = 1'b0;
        pulse_req();
        collect(0, 6, got, n, cyc, bad);
        tests_run++; if (got !== FRAME_Z) begin tests_failed++; $display("FAIL zero_bytes: got %h want %h", got, FRAME_Z); end
        tests_run++; if (n !== 6) begin tests_failed++; $display("FAIL zero_count: got %0d want 6", n); end
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL zero_done: got %b want 1", done); end
        @(negedge clk);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1; req = 1'b0; tx_ready = 1'b1;
        r8 = 8'h00; r13 = 13'h0; r5 = 5'h0; r3 = 3'd0; r1 = 1'b0;
        test_reset();
        test_normal();
        test_backpressure();
        test_input_change();
        test_held_req();
        test_reset_mid();
        test_zeros();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
